// File: rtl/subtractor_bitserial.sv
// subtractor_bitserial: LSB-first bit-serial a - b - bin over WIDTH cycles; defining SUBTRACTOR_BITSERIAL_OVF_EN adds the signed-overflow output ovf
module subtractor_bitserial #(
  parameter int WIDTH = 8,
  parameter int IMPL_TYPE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero
`ifdef SUBTRACTOR_BITSERIAL_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, diff_q, diff_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic br_q, br_d, bout_q, bout_d, zero_q, zero_d;
  logic ca, cb, sub, cbo, last;
  assign ca = a_q[0];
  assign cb = b_q[0];
  generate
    if (IMPL_TYPE == 0) begin : g_xor
      logic x;
      assign x = ca ^ cb;
      assign sub = x ^ br_q;
      assign cbo = x ? cb : br_q;
    end else if (IMPL_TYPE == 1) begin : g_maj
      logic na;
      assign na = ~ca;
      assign cbo = (na & cb) | (na & br_q) | (cb & br_q);
      assign sub = ~(na ^ cb ^ br_q);
    end else begin : g_bad
      $fatal(1, "subtractor_bitserial: unsupported IMPL_TYPE %0d", IMPL_TYPE);
      assign sub = 1'b0;
      assign cbo = 1'b0;
    end
  endgenerate
  assign last = cnt_q == CW'(WIDTH - 1);
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign diff = diff_q;
  assign bout = bout_q;
  assign zero = zero_q;
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    br_d = br_q;
    cnt_d = cnt_q;
    res_d = res_q;
    diff_d = diff_q;
    bout_d = bout_q;
    zero_d = zero_q;
    if (state_q == IDLE && in_valid) begin
      state_d = RUN;
      a_d = a;
      b_d = b;
      br_d = bin;
      cnt_d = '0;
    end else if (state_q == RUN) begin
      a_d = a_q >> 1;
      b_d = b_q >> 1;
      br_d = cbo;
      cnt_d = cnt_q + CW'(1);
      res_d = (res_q >> 1) | (WIDTH'(sub) << (WIDTH - 1));
      if (last) begin
        state_d = DONE;
        diff_d = res_d;
        bout_d = cbo;
        zero_d = res_d == '0;
      end
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      br_q <= 1'b0;
      cnt_q <= '0;
      res_q <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      br_q <= br_d;
      cnt_q <= cnt_d;
      res_q <= res_d;
      diff_q <= diff_d;
      bout_q <= bout_d;
      zero_q <= zero_d;
    end
  end
`ifdef SUBTRACTOR_BITSERIAL_OVF_EN
  logic ovf_q, ovf_d;
  always_comb ovf_d = (state_q == RUN && last) ? (ca != cb) && (sub != ca) : ovf_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else ovf_q <= ovf_d;
  end
  assign ovf = ovf_q;
`endif
endmodule

// File: tb/tb_subtractor_bitserial.sv
// tb_subtractor_bitserial: scoreboard bench for subtractor_bitserial, directed cases plus random regression over several widths
module tb_subtractor_bitserial;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int n_tests = 0;
  int n_fail = 0;
  int n_done = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  typedef struct packed {
    logic [7:0] d;
    logic bo;
    logic z;
    logic ov;
  } exp_t;
  function automatic exp_t model(input logic [7:0] av, input logic [7:0] bv, input logic bi);
    logic [8:0] r;
    r = {1'b0, av} - {1'b0, bv} - 9'(bi);
    model.d = r[7:0];
    model.bo = r[8];
    model.z = r[7:0] == 8'h00;
    model.ov = (av[7] != bv[7]) && (r[7] != av[7]);
  endfunction
  logic rst = 1'b1;
  logic rst_r = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic bin = 1'b0;
  logic in_ready, out_valid, bout, zero;
  logic [7:0] diff;
`ifdef SUBTRACTOR_BITSERIAL_OVF_EN
  logic ovf;
`endif
  subtractor_bitserial #(.WIDTH(8), .IMPL_TYPE(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .zero(zero)
`ifdef SUBTRACTOR_BITSERIAL_OVF_EN
    , .ovf(ovf)
`endif
  );
  exp_t q[$];
  task automatic op(input logic [7:0] av, input logic [7:0] bv, input logic bi, input int hold);
    exp_t e;
    int lat;
    check("accept_ready", in_ready, 1);
    a = av;
    b = bv;
    bin = bi;
    in_valid = 1'b1;
    q.push_back(model(av, bv, bi));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    bin = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", lat, 8);
    if (q.size() == 0) begin
      check("queue_empty", 1, 0);
      return;
    end
    e = q.pop_front();
    check("diff", diff, e.d);
    check("bout", bout, e.bo);
    check("zero", zero, e.z);
`ifdef SUBTRACTOR_BITSERIAL_OVF_EN
    check("ovf", ovf, e.ov);
`endif
    repeat (hold) begin
      in_valid = 1'b1;
      a = 8'($urandom);
      b = 8'($urandom);
      @(posedge clk);
      #1;
      check("hold_valid", out_valid, 1);
      check("hold_ready", in_ready, 0);
      check("hold_diff", diff, e.d);
      check("hold_bout", bout, e.bo);
      check("hold_zero", zero, e.z);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("release_valid", out_valid, 0);
    check("release_ready", in_ready, 1);
  endtask
  for (genvar g = 0; g < 5; g++) begin : rnd
    localparam int W = g < 2 ? 1 : (g < 4 ? 13 : 8);
    localparam int I = g == 4 ? 1 : g % 2;
    logic iv = 1'b0;
    logic orr = 1'b0;
    logic bi = 1'b0;
    logic [W-1:0] av = '0;
    logic [W-1:0] bv = '0;
    logic ir, ov, bo, z;
    logic [W-1:0] d;
`ifdef SUBTRACTOR_BITSERIAL_OVF_EN
    logic of;
`endif
    subtractor_bitserial #(.WIDTH(W), .IMPL_TYPE(I)) u (
      .clk(clk), .rst(rst_r), .in_valid(iv), .in_ready(ir),
      .a(av), .b(bv), .bin(bi), .out_valid(ov), .out_ready(orr),
      .diff(d), .bout(bo), .zero(z)
`ifdef SUBTRACTOR_BITSERIAL_OVF_EN
      , .ovf(of)
`endif
    );
    logic [W:0] rq[$];
    initial begin
      int lat;
      logic [W:0] e;
      wait (rst_r == 1'b0);
      for (int i = 0; i < 200; i++) begin
        @(posedge clk);
        #1;
        av = W'($urandom);
        bv = W'($urandom);
        bi = 1'($urandom);
        check($sformatf("r%0d_ready", g), ir, 1);
        iv = 1'b1;
        rq.push_back({1'b0, av} - {1'b0, bv} - (W + 1)'(bi));
        @(posedge clk);
        #1;
        iv = 1'b0;
        lat = 0;
        while (!ov && lat < W + 5) begin
          @(posedge clk);
          #1;
          lat++;
        end
        check($sformatf("r%0d_latency", g), lat, W);
        if (rq.size() == 0) begin
          check($sformatf("r%0d_queue", g), 1, 0);
        end else begin
          e = rq.pop_front();
          check($sformatf("r%0d_diff", g), d, e[W-1:0]);
          check($sformatf("r%0d_bout", g), bo, e[W]);
          check($sformatf("r%0d_zero", g), z, e[W-1:0] == '0);
        end
        orr = 1'b1;
        @(posedge clk);
        #1;
        orr = 1'b0;
      end
      n_done++;
    end
  end
  initial begin
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_diff", diff, 0);
    check("rst_bout", bout, 0);
    check("rst_zero", zero, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    rst_r = 1'b0;
    op(8'h5A, 8'h1F, 1'b0, 5);
    op(8'h00, 8'h01, 1'b0, 0);
    op(8'h80, 8'h80, 1'b0, 0);
    op(8'h80, 8'h80, 1'b1, 0);
    a = 8'h33;
    b = 8'h11;
    bin = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrun_valid", out_valid, 0);
    check("midrun_diff", diff, 0);
    check("midrun_ready", in_ready, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    op(8'h10, 8'h01, 1'b0, 0);
`ifdef SUBTRACTOR_BITSERIAL_OVF_EN
    op(8'h80, 8'h01, 1'b0, 0);
    op(8'h7F, 8'hFF, 1'b0, 0);
    op(8'h05, 8'h03, 1'b0, 0);
`endif
    for (int i = 0; i < 300; i++) op(8'($urandom), 8'($urandom), 1'($urandom), i % 7 == 0 ? 2 : 0);
    for (int t = 0; t < 20000 && n_done != 5; t++) @(posedge clk);
    check("random_done", n_done, 5);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
